// File: rtl/axi_pkg.sv
// Shared AXI4 constants, scheduler state encoding and a constant-safe clog2
// used by the write-channel scheduler and its arbiter.
package axi_pkg;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_EXOKAY     = 2'b01;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [1:0] RESP_DECERR     = 2'b11;
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from the pointer,
// pointer moves to one past the served index when advance is strobed.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic [IW-1:0] ptr
);

  always_comb begin
    int c;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    c         = 0;
    // Walk offsets high to low so the smallest offset from ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(c);
      end
    end
    gnt[gnt_idx] = gnt_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (adv_idx == IW'(N - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_sched.sv
// Shares one AXI4 write port between NUM_REQ requesters, one burst in flight:
// arbitrate, issue AW, forward the winner's W beats with WLAST, return B.
module axi_wr_sched
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 7,
  parameter int USER_WIDTH = 5,
  parameter int NUM_REQ    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]           req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [NUM_REQ-1:0]             req_wvalid,
  output logic [NUM_REQ-1:0]             req_wready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [1:0]                     rsp_resp,
  output logic [ID_WIDTH-1:0]            m_axi_awid,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [7:0]                     m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awlock,
  output logic [3:0]                     m_axi_awcache,
  output logic [2:0]                     m_axi_awprot,
  output logic [3:0]                     m_axi_awqos,
  output logic [USER_WIDTH-1:0]          m_axi_awuser,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic [USER_WIDTH-1:0]          m_axi_wuser,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [ID_WIDTH-1:0]            m_axi_bid,
  input  logic [1:0]                     m_axi_bresp,
  input  logic [USER_WIDTH-1:0]          m_axi_buser,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  output state_t                         dbg_state
);

  localparam int IW     = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Every channel transfers on a clock edge where valid and ready are both
  // high; a valid, once raised, holds its payload stable until that edge.
  state_t                  state;
  logic [IW-1:0]           g;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           ptr;
  logic [NUM_REQ-1:0]      gnt;
  logic                    gnt_valid;
  logic [NUM_REQ-1:0]      g_onehot;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [7:0]              sel_len;
  logic [7:0]              cnt;
  logic                    w_fire;
  logic                    b_fire;
  logic                    unused_buser;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (b_fire),
    .adv_idx   (g),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  assign unused_buser  = ^{m_axi_buser, ptr};
  assign req_ready     = (state == ST_IDLE) ? gnt : '0;
  assign m_axi_awvalid = (state == ST_AW);
  assign m_axi_bready  = (state == ST_B);
  assign m_axi_wlast   = (state == ST_W) && (cnt == m_axi_awlen);
  assign w_fire        = m_axi_wvalid && m_axi_wready;
  assign b_fire        = m_axi_bvalid && m_axi_bready;
  assign dbg_state     = state;

  assign m_axi_awsize  = 3'(clog2(STRB_W));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AWCACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awuser  = '0;
  assign m_axi_wuser   = '0;

  // Command fields follow the arbiter winner; W path follows the latched owner.
  always_comb begin
    sel_addr     = '0;
    sel_len      = '0;
    g_onehot     = '0;
    m_axi_wdata  = '0;
    m_axi_wstrb  = '0;
    m_axi_wvalid = 1'b0;
    req_wready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*8 +: 8];
      end
      if (IW'(i) == g) begin
        g_onehot[i] = 1'b1;
        m_axi_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axi_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        if (state == ST_W) begin
          m_axi_wvalid  = req_wvalid[i];
          req_wready[i] = m_axi_wready;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      g            <= '0;
      m_axi_awid   <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen  <= '0;
      cnt          <= '0;
      rsp_valid    <= '0;
      rsp_resp     <= RESP_OKAY;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            g            <= gnt_idx;
            m_axi_awid   <= ID_WIDTH'(gnt_idx);
            m_axi_awaddr <= sel_addr;
            m_axi_awlen  <= sel_len;
            state        <= ST_AW;
          end
        end
        ST_AW: begin
          if (m_axi_awready) state <= ST_W;
        end
        ST_W: begin
          if (w_fire) begin
            if (m_axi_wlast) begin
              cnt   <= '0;
              state <= ST_B;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            rsp_valid <= g_onehot;
            // A response carrying another ID cannot belong to this burst.
            rsp_resp  <= (m_axi_bid != m_axi_awid) ? RESP_SLVERR : m_axi_bresp;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched: requester and slave models stepped once per
// cycle, handshakes logged at the falling edge, checks inline per scenario.
module tb_axi_wr_sched;
  import axi_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 7;
  localparam int UW  = 5;
  localparam int NR  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]      req_valid, req_ready, req_wvalid, req_wready, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*8-1:0]    req_len;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR*DW/8-1:0] req_wstrb;
  logic [1:0]         rsp_resp;
  logic [IDW-1:0]     m_axi_awid, m_axi_bid;
  logic [AW-1:0]      m_axi_awaddr;
  logic [7:0]         m_axi_awlen;
  logic [2:0]         m_axi_awsize, m_axi_awprot;
  logic [1:0]         m_axi_awburst, m_axi_bresp;
  logic               m_axi_awlock, m_axi_awvalid, m_axi_awready;
  logic [3:0]         m_axi_awcache, m_axi_awqos;
  logic [UW-1:0]      m_axi_awuser, m_axi_wuser, m_axi_buser;
  logic [DW-1:0]      m_axi_wdata;
  logic [DW/8-1:0]    m_axi_wstrb;
  logic               m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic               m_axi_bvalid, m_axi_bready;
  state_t             dbg_state;

  axi_wr_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW),
                 .USER_WIDTH(UW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_wvalid(req_wvalid), .req_wready(req_wready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .dbg_state(dbg_state)
  );

  typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } aw_rec_t;
  typedef struct { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } w_rec_t;
  typedef struct { logic [NR-1:0] v; logic [1:0] resp; int cyc; } rsp_rec_t;
  typedef struct { int r; int cyc; } acc_rec_t;

  aw_rec_t        aw_q[$];
  w_rec_t         w_q[$];
  rsp_rec_t       rsp_q[$];
  acc_rec_t       acc_q[$];
  logic [DW-1:0]  exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic           cmd_pend[NR];
  logic [AW-1:0]  cmd_addr[NR];
  logic [7:0]     cmd_len[NR];
  logic           w_act[NR];
  int             beat_idx[NR];
  bit             gap_mode, w_toggle, bid_bad, stray_b, aw_done, aw_hold;
  int             aw_stall, aw_wait, gap_cnt;
  logic [1:0]     b_resp_k;
  logic           b_pend;
  logic [IDW-1:0] b_id;
  aw_rec_t        aw_prev;
  int             aw_unstable, w_early, ready_bad;

  function automatic logic [DW-1:0] beat_data(input int r, input int k);
    return {8'(r), 8'hA5, 16'(k)};
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < NR; r++) begin
      req_valid[r]           = cmd_pend[r];
      req_addr[r*AW +: AW]   = cmd_addr[r];
      req_len[r*8 +: 8]      = cmd_len[r];
      req_wdata[r*DW +: DW]  = beat_data(r, beat_idx[r]);
      req_wstrb[r*4 +: 4]    = 4'hF;
      req_wvalid[r]          = w_act[r] && !(gap_mode && (gap_cnt % 3 == 0));
    end
    m_axi_awready = (aw_wait >= aw_stall);
    m_axi_wready  = w_toggle ? (gap_cnt % 2 == 0) : 1'b1;
    m_axi_bvalid  = b_pend || stray_b;
    m_axi_bid     = bid_bad ? ~b_id : b_id;
    m_axi_bresp   = b_resp_k;
    m_axi_buser   = '0;
  endtask

  task automatic clear_queues();
    aw_q.delete(); w_q.delete(); rsp_q.delete(); acc_q.delete(); exp_q.delete();
  endtask

  task automatic clear_model();
    for (int r = 0; r < NR; r++) begin
      cmd_pend[r] = 1'b0; cmd_addr[r] = '0; cmd_len[r] = '0;
      w_act[r] = 1'b0; beat_idx[r] = 0;
    end
    gap_mode = 0; w_toggle = 0; bid_bad = 0; stray_b = 0; aw_done = 0; aw_hold = 0;
    aw_stall = 0; aw_wait = 0; gap_cnt = 0; b_resp_k = 2'b00; b_pend = 1'b0; b_id = '0;
    aw_unstable = 0; w_early = 0; ready_bad = 0;
    clear_queues();
  endtask

  task automatic issue(input int r, input logic [AW-1:0] addr, input logic [7:0] len);
    cmd_pend[r] = 1'b1;
    cmd_addr[r] = addr;
    cmd_len[r]  = len;
    for (int k = 0; k <= int'(len); k++) exp_q.push_back(beat_data(r, k));
    drive_inputs();
  endtask

  // One clock: log handshakes at the falling edge, then advance models after the rising edge.
  task automatic step();
    bit cf[NR];
    bit wf[NR];
    bit awf, wfm, wl, bf;
    @(negedge clk);
    awf = m_axi_awvalid && m_axi_awready;
    wfm = m_axi_wvalid && m_axi_wready;
    wl  = m_axi_wlast;
    bf  = m_axi_bvalid && m_axi_bready;
    for (int r = 0; r < NR; r++) begin
      cf[r] = req_valid[r] && req_ready[r];
      wf[r] = req_wvalid[r] && req_wready[r];
      if (cf[r]) acc_q.push_back('{r, cyc});
    end
    if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) ready_bad++;
    if (m_axi_wvalid && !aw_done) w_early++;
    if (aw_hold && (m_axi_awvalid !== 1'b1 || m_axi_awid !== aw_prev.id ||
        m_axi_awaddr !== aw_prev.addr || m_axi_awlen !== aw_prev.len)) aw_unstable++;
    aw_hold = m_axi_awvalid && !m_axi_awready;
    aw_prev = '{m_axi_awid, m_axi_awaddr, m_axi_awlen};
    if (awf) begin
      aw_q.push_back('{m_axi_awid, m_axi_awaddr, m_axi_awlen});
      aw_done = 1;
      b_id = m_axi_awid;
      aw_wait = 0;
    end else if (m_axi_awvalid) begin
      aw_wait++;
    end
    if (wfm) begin
      w_q.push_back('{m_axi_wdata, m_axi_wstrb, wl});
      if (wl) aw_done = 0;
    end
    if (rsp_valid != '0) rsp_q.push_back('{rsp_valid, rsp_resp, cyc});
    @(posedge clk);
    cyc++;
    #1;
    for (int r = 0; r < NR; r++) begin
      if (cf[r]) begin cmd_pend[r] = 1'b0; w_act[r] = 1'b1; beat_idx[r] = 0; end
      if (wf[r]) begin
        beat_idx[r]++;
        if (beat_idx[r] > int'(cmd_len[r])) w_act[r] = 1'b0;
      end
    end
    if (bf) b_pend = 1'b0;
    if (wfm && wl) b_pend = 1'b1;
    gap_cnt++;
    drive_inputs();
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < budget) begin step(); k++; end
    ok = (rsp_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 2'b00 || req_wready !== 2'b00 || rsp_valid !== 2'b00) begin
      bad++; $display("FAIL reset_req_side: ready=%b wready=%b rsp=%b want 0", req_ready, req_wready, rsp_valid); end
    total++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0) begin
      bad++; $display("FAIL reset_axi_side: awv=%b wv=%b br=%b want 0", m_axi_awvalid, m_axi_wvalid, m_axi_bready); end
    total++; if (m_axi_awaddr !== '0 || m_axi_awlen !== '0 || m_axi_awid !== '0) begin
      bad++; $display("FAIL reset_aw_regs: addr=%h len=%h id=%h want 0", m_axi_awaddr, m_axi_awlen, m_axi_awid); end
    total++; if (dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    step(); step();
    total++; if (m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01 || m_axi_awcache !== 4'b0011) begin
      bad++; $display("FAIL aw_consts: size=%0d burst=%b cache=%b want 2/01/0011", m_axi_awsize, m_axi_awburst, m_axi_awcache); end
    total++; if (m_axi_awlock !== 1'b0 || m_axi_awprot !== 3'd0 || m_axi_awqos !== 4'd0 ||
                 m_axi_awuser !== '0 || m_axi_wuser !== '0) begin
      bad++; $display("FAIL aw_zero_fields: lock=%b prot=%h qos=%h awuser=%h wuser=%h want 0",
                      m_axi_awlock, m_axi_awprot, m_axi_awqos, m_axi_awuser, m_axi_wuser); end
    stray_b = 1; drive_inputs();
    repeat (3) step();
    total++; if (m_axi_bready !== 1'b0 || rsp_q.size() != 0) begin
      bad++; $display("FAIL stray_bvalid: bready=%b rsps=%0d want 0/0", m_axi_bready, rsp_q.size()); end
    stray_b = 0; drive_inputs();
    step();
  endtask

  task automatic test_contention();
    bit ok;
    clear_queues();
    issue(0, 32'h0000_0100, 8'd1);
    issue(1, 32'h0000_0200, 8'd1);
    wait_rsp(2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_timeout: rsps=%0d want 2", rsp_q.size()); end
    if (ok) begin
      total++; if (acc_q[0].r != 0 || acc_q[1].r != 1) begin
        bad++; $display("FAIL cont_order: got %0d,%0d want 0,1", acc_q[0].r, acc_q[1].r); end
      total++; if (aw_q[0].id !== 7'd0 || aw_q[1].id !== 7'd1 || aw_q[1].addr !== 32'h200) begin
        bad++; $display("FAIL cont_awid: ids %0d,%0d addr1 %h want 0,1,200", aw_q[0].id, aw_q[1].id, aw_q[1].addr); end
      total++; if (rsp_q[0].v !== 2'b01 || rsp_q[1].v !== 2'b10) begin
        bad++; $display("FAIL cont_rsp: got %b,%b want 01,10", rsp_q[0].v, rsp_q[1].v); end
      for (int k = 0; k < 4; k++) begin
        total++; if (k >= w_q.size() || w_q[k].data !== exp_q[k]) begin
          bad++; $display("FAIL cont_wdata[%0d]: got %h want %h", k, (k < w_q.size()) ? w_q[k].data : '0, exp_q[k]); end
      end
    end
    total++; if (ready_bad != 0) begin bad++; $display("FAIL cont_ready_onehot: violations=%0d want 0", ready_bad); end
    clear_queues();
    issue(0, 32'h0000_0300, 8'd0);
    issue(1, 32'h0000_0400, 8'd0);
    wait_rsp(2, 100, ok);
    total++; if (acc_q.size() < 1 || acc_q[0].r != 0) begin
      bad++; $display("FAIL cont_next_tie: got %0d want 0", (acc_q.size() > 0) ? acc_q[0].r : -1); end
  endtask

  task automatic test_single();
    bit ok;
    clear_queues();
    issue(0, 32'h0000_1000, 8'd3);
    wait_rsp(1, 100, ok);
    repeat (3) step();
    total++; if (!ok || rsp_q.size() != 1) begin bad++; $display("FAIL single_rsp_count: got %0d want 1", rsp_q.size()); end
    if (ok) begin
      total++; if (aw_q.size() != 1 || aw_q[0].id !== 7'd0 || aw_q[0].addr !== 32'h1000 || aw_q[0].len !== 8'd3) begin
        bad++; $display("FAIL single_aw: id=%0d addr=%h len=%0d want 0/1000/3", aw_q[0].id, aw_q[0].addr, aw_q[0].len); end
      total++; if (w_q.size() != 4) begin bad++; $display("FAIL single_beats: got %0d want 4", w_q.size()); end
      for (int k = 0; k < 4 && k < w_q.size(); k++) begin
        total++; if (w_q[k].data !== exp_q[k] || w_q[k].strb !== 4'hF || w_q[k].last !== (k == 3)) begin
          bad++; $display("FAIL single_beat[%0d]: data=%h strb=%h last=%b want %h/f/%b",
                          k, w_q[k].data, w_q[k].strb, w_q[k].last, exp_q[k], k == 3); end
      end
      total++; if (rsp_q[0].v !== 2'b01 || rsp_q[0].resp !== 2'b00) begin
        bad++; $display("FAIL single_resp: v=%b resp=%b want 01/00", rsp_q[0].v, rsp_q[0].resp); end
      total++; if (rsp_q[0].cyc - acc_q[0].cyc != 7) begin
        bad++; $display("FAIL single_latency: got %0d want 7", rsp_q[0].cyc - acc_q[0].cyc); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_queues();
    aw_stall = 5; w_toggle = 1; gap_mode = 1; aw_unstable = 0; w_early = 0;
    issue(0, 32'h0000_2000, 8'd7);
    wait_rsp(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: rsps=%0d want 1", rsp_q.size()); end
    total++; if (aw_unstable != 0 || w_early != 0) begin
      bad++; $display("FAIL bp_aw_hold: unstable=%0d early_w=%0d want 0/0", aw_unstable, w_early); end
    total++; if (aw_q.size() != 1 || aw_q[0].addr !== 32'h2000 || aw_q[0].len !== 8'd7) begin
      bad++; $display("FAIL bp_aw: count=%0d want 1 addr 2000 len 7", aw_q.size()); end
    total++; if (w_q.size() != 8) begin bad++; $display("FAIL bp_beats: got %0d want 8", w_q.size()); end
    for (int k = 0; k < 8 && k < w_q.size(); k++) begin
      total++; if (w_q[k].data !== exp_q[k] || w_q[k].last !== (k == 7)) begin
        bad++; $display("FAIL bp_beat[%0d]: data=%h last=%b want %h/%b", k, w_q[k].data, w_q[k].last, exp_q[k], k == 7); end
    end
    aw_stall = 0; w_toggle = 0; gap_mode = 0; drive_inputs();
  endtask

  task automatic test_boundaries();
    bit ok;
    int lasts;
    clear_queues();
    issue(1, 32'h0000_5000, 8'd0);
    wait_rsp(1, 100, ok);
    total++; if (!ok || w_q.size() != 1 || w_q[0].last !== 1'b1 || w_q[0].data !== exp_q[0]) begin
      bad++; $display("FAIL len0_beat: beats=%0d want 1 with last", w_q.size()); end
    total++; if (aw_q.size() != 1 || aw_q[0].len !== 8'd0 || aw_q[0].id !== 7'd1) begin
      bad++; $display("FAIL len0_aw: count=%0d want 1 len 0 id 1", aw_q.size()); end
    clear_queues();
    issue(0, 32'h0000_6000, 8'd255);
    wait_rsp(1, 400, ok);
    total++; if (w_q.size() != 256) begin bad++; $display("FAIL len255_beats: got %0d want 256", w_q.size()); end
    lasts = 0;
    foreach (w_q[k]) if (w_q[k].last) lasts++;
    total++; if (w_q.size() != 256 || lasts != 1 || w_q[255].last !== 1'b1 || w_q[255].data !== exp_q[255]) begin
      bad++; $display("FAIL len255_last: lasts=%0d want 1 on beat 256", lasts); end
    total++; if (!ok || rsp_q[0].cyc - acc_q[0].cyc != 259) begin
      bad++; $display("FAIL len255_latency: got %0d want 259", ok ? rsp_q[0].cyc - acc_q[0].cyc : -1); end
  endtask

  task automatic test_resp_errors();
    bit ok;
    clear_queues();
    b_resp_k = 2'b11;
    issue(0, 32'h0000_7000, 8'd0);
    wait_rsp(1, 100, ok);
    total++; if (!ok || rsp_q[0].resp !== 2'b11) begin
      bad++; $display("FAIL resp_decerr: got %b want 11", ok ? rsp_q[0].resp : 2'b00); end
    clear_queues();
    b_resp_k = 2'b00; bid_bad = 1;
    issue(1, 32'h0000_8000, 8'd0);
    wait_rsp(1, 100, ok);
    total++; if (!ok || rsp_q[0].resp !== 2'b10 || rsp_q[0].v !== 2'b10) begin
      bad++; $display("FAIL resp_bid_mismatch: resp=%b v=%b want 10/10", ok ? rsp_q[0].resp : 2'b00, ok ? rsp_q[0].v : 2'b00); end
    bid_bad = 0; drive_inputs();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    clear_queues();
    issue(0, 32'h0000_9000, 8'd3);
    k = 0;
    while (w_q.size() < 2 && k < 100) begin step(); k++; end
    total++; if (w_q.size() != 2) begin bad++; $display("FAIL rstmid_reach: beats=%0d want 2", w_q.size()); end
    rst = 1'b1;
    #1;
    total++; if (m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b0 || m_axi_bready !== 1'b0 ||
                 req_wready !== 2'b00 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      bad++; $display("FAIL rstmid_outputs: wv=%b awv=%b br=%b wr=%b rr=%b rsp=%b want 0",
                      m_axi_wvalid, m_axi_awvalid, m_axi_bready, req_wready, req_ready, rsp_valid); end
    total++; if (dbg_state !== ST_IDLE || m_axi_awaddr !== '0 || m_axi_awlen !== '0) begin
      bad++; $display("FAIL rstmid_state: state=%0d addr=%h len=%h want 0", dbg_state, m_axi_awaddr, m_axi_awlen); end
    clear_model();
    drive_inputs();
    step(); step();
    rst = 1'b0;
    step();
    issue(1, 32'h0000_A000, 8'd1);
    wait_rsp(1, 100, ok);
    total++; if (!ok || aw_q[0].id !== 7'd1 || aw_q[0].addr !== 32'hA000 || rsp_q[0].v !== 2'b10) begin
      bad++; $display("FAIL rstmid_after: rsps=%0d want req1 served id 1 addr a000", rsp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    clear_model();
    drive_inputs();
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_boundaries();
    test_resp_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
Write-channel scheduler that shares one AXI4 master write port (AW/W/B) between NUM_REQ local requesters.
- Round-robin arbitration; one burst in flight at a time.
- Issues AW, forwards the granted requester's W beats with generated WLAST, routes the B response back.
- Sits between DMA/engine clients and the subsystem's m_axi_* master port. The read channel is out of scope.

Parameters:
DATA_WIDTH, 32, AXI data width (bits).
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 7, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_REQ.
USER_WIDTH, 5, AXI user-signal width.
NUM_REQ, 2, number of requesters; must be 2..8.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept
req_addr  in  NUM_REQ*ADDR_WIDTH  burst start address; slice i belongs to requester i
req_len  in  NUM_REQ*8  AXI LEN, where beats = len+1
req_wdata  in  NUM_REQ*DATA_WIDTH  write data
req_wstrb  in  NUM_REQ*DATA_WIDTH/8  write strobes
req_wvalid  in  NUM_REQ  data valid
req_wready  out  NUM_REQ  data accept
rsp_valid  out  NUM_REQ  one-cycle completion pulse
rsp_resp  out  2  response code, qualified by any rsp_valid bit
m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,user,valid}  out  standard AXI4 widths  write address channel
m_axi_awready  in  1  write address ready
m_axi_w{data,strb,last,user,valid}  out  standard AXI4 widths  write data channel
m_axi_wready  in  1  write data ready
m_axi_b{id,resp,user,valid}  in  standard AXI4 widths  write response channel
m_axi_bready  out  1  write response ready

Behaviour:
- Reset state:
  - State IDLE, round-robin pointer 0.
  - All valid, ready and rsp outputs 0.
  - Registered awaddr, awlen and awid cleared to 0.
  - The same values apply when reset is asserted mid-burst. The AXI slave must be reset in the same domain; no partial-burst recovery is provided.
- Constant AW fields:
  - awsize = clog2(DATA_WIDTH/8).
  - awburst = 2'b01 (INCR).
  - awlock = 0, awcache = 4'b0011, awprot = 0, awqos = 0, awuser = 0, wuser = 0.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - Grant = first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[grant] is driven combinationally high in the same cycle; all other ready bits stay 0.
  - On that handshake: latch addr, len and grant index; awid = grant index, zero-extended; go to AW.
- AW:
  - m_axi_awvalid = 1 from the cycle after acceptance.
  - Fields hold stable until m_axi_awready is seen; then go to W.
- W:
  - m_axi_wvalid = req_wvalid[g]; wdata/wstrb are muxed from slice g.
  - req_wready[g] = m_axi_wready; other wready bits are 0.
  - An 8-bit beat counter increments on each W handshake.
  - m_axi_wlast = (cnt == latched len).
  - Handshake with wlast = 1 moves to B and clears the counter.
  - No W is driven before the AW handshake completes.
- B:
  - m_axi_bready = 1.
  - On bvalid: rsp_valid[g] = 1 for exactly one cycle, rsp_resp = bresp.
  - If bid != latched awid, rsp_resp is forced to 2'b10 (SLVERR).
  - Pointer = (g+1) mod NUM_REQ; go to IDLE.
  - Earliest next req_ready is the following cycle.
- Minimum burst latency, from command accept to rsp_valid, is 3 + beats cycles with zero-wait slave.
- Boundary conditions:
  - len = 0 gives a single beat with wlast = 1 on the first beat.
  - len = 255 gives 256 beats; the counter must not wrap before the last beat.
  - Simultaneous req_valid bits: only the granted requester sees ready; the others hold their valid.
  - bvalid outside state B is ignored (bready = 0).
  - 4KB-boundary crossing is the requester's responsibility; bursts are never split.

Decomposition:
- Package axi_pkg: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, AWCACHE_DEFAULT, the state enum, and a clog2 function.
- Sub-module rr_arbiter (parameter N):
  - Combinational grant from request vector and pointer.
  - one-hot plus index output.
  - Registered pointer update on an advance strobe.

Test Plan:
- Single write: req0 addr 0x1000, len 3, zero-wait slave -> awid 0, awaddr 0x1000, awlen 3, 4 W beats with wlast on beat 4, rsp_valid[0] pulse, resp 0.
- Contention: req0 and req1 both valid in the same cycle, pointer 0 -> req0 served first, then req1 (awid 1); next tie goes to req0.
- Backpressure: awready low 5 cycles, wready toggling, req_wvalid gaps, len 7 -> AW fields stable, exactly 8 beats, wlast only on beat 8.
- Boundaries: len 0 -> single beat with wlast; len 255 -> 256 beats, counter correct.
- Response errors: bresp 2'b11 -> rsp_resp 2'b11; bid mismatch with bresp 0 -> rsp_resp 2'b10.
- Reset mid-W: assert rst after beat 2 of 4 -> all outputs 0 immediately, state IDLE; after release, a new req1 command is granted normally.
